pattern_scan_ctrl: RTL



---
 rtl/pattern_scan_ctrl_pkg.sv | 14 +
 rtl/pattern_scan_ctrl_if.sv | 27 ++
 rtl/pattern_scan_ctrl_match_core.sv | 67 ++++++
 rtl/pattern_scan_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/pattern_scan_ctrl_pkg.sv
// pattern_scan_pkg: shared types and defaults for the pattern scan controller.
// Holds the controller state encoding and the default pattern constants.
package pattern_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int             DEF_PAT_W = 4;
  localparam logic [3:0]     DEF_PAT   = 4'b0110;

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// pattern_scan_ctrl_if: word input and result handshakes of the scan controller.
//   in_valid/in_ready/in_word      : producer -> controller word transfer
//   out_valid/out_ready            : controller -> consumer result transfer
//   out_count/out_hit              : result payload
// master = producer/consumer side, slave = controller side.
interface pattern_scan_ctrl_if #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_word;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic              out_hit;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_count, out_hit
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_count, out_hit
  );
endinterface

// File: rtl/pattern_scan_ctrl_match_core.sv
// pattern_match_core: bit-serial overlapping pattern matcher.
//   clk, reset  : clock, synchronous active-high reset
//   clr         : clears history, fill count and match flag
//   bit_valid   : bit_in is a new serial bit this cycle
//   bit_in      : serial data, oldest bit first
//   match       : registered, high the cycle after the bit completing a match
//   match_next  : combinational "this bit completes a match", lets the
//                 controller count the final bit of a word at the same edge
module pattern_match_core
  import pattern_scan_pkg::*;
#(
  parameter int               PAT_W = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT   = DEF_PAT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic bit_valid,
  input  logic bit_in,
  output logic match,
  output logic match_next
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              match_q;

  // History shift, saturating fill count and match detection.
  always_comb begin
    hist_d     = hist_q;
    fill_d     = fill_q;
    match_next = 1'b0;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (bit_valid) begin
      hist_d = {hist_q[PAT_W-2:0], bit_in};
      if (fill_q < FILL_W'(PAT_W)) begin
        fill_d = fill_q + FILL_W'(1);
      end else begin
        fill_d = fill_q;
      end
      // History is never cleared on a match, so overlaps are counted.
      match_next = (fill_d == FILL_W'(PAT_W)) && (hist_d == PAT);
    end else begin
      hist_d = hist_q;
    end
  end

  // History, fill and registered match state.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_next;
    end
  end

  assign match = match_q;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: accepts a word, scans it MSB-first through the serial
// matcher and returns the saturating match count and hit flag.
//   clk, reset  : clock, synchronous active-high reset
//   bus         : word input and result handshakes (slave side)
//   match_pulse : one-cycle pulse per detected match
//   busy        : controller not in IDLE
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int               WORD_W = 8,
  parameter int               PAT_W  = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT    = DEF_PAT,
  parameter int               CNT_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  pattern_scan_ctrl_if.slave  bus,
  output logic                match_pulse,
  output logic                busy
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              hit_q, hit_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              core_clr, core_bit_valid, core_bit;
  logic              core_match, core_match_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  pattern_match_core #(.PAT_W(PAT_W), .PAT(PAT)) u_core (
    .clk        (clk),
    .reset      (reset),
    .clr        (core_clr),
    .bit_valid  (core_bit_valid),
    .bit_in     (core_bit),
    .match      (core_match),
    .match_next (core_match_next)
  );

  // Next-state, datapath and handshake decode.
  always_comb begin
    state_d        = state_q;
    word_d         = word_q;
    idx_d          = idx_q;
    count_d        = count_q;
    hit_d          = hit_q;
    core_clr       = 1'b0;
    core_bit_valid = 1'b0;
    core_bit       = word_q[idx_q];
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          word_d   = bus.in_word;
          idx_d    = IDX_W'(WORD_W - 1);
          count_d  = '0;
          hit_d    = 1'b0;
          core_clr = 1'b1;
          state_d  = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        core_bit_valid = 1'b1;
        if (core_match_next) begin
          count_d = sat_inc(count_q);
          hit_d   = 1'b1;
        end else begin
          count_d = count_q;
        end
        if (idx_q == IDX_W'(0)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Handshake flags are registered versions of the next state.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State, datapath and registered output flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      word_q      <= '0;
      idx_q       <= '0;
      count_q     <= '0;
      hit_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      hit_q       <= hit_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_count = count_q;
  assign bus.out_hit   = hit_q;
  assign match_pulse   = core_match;
  assign busy          = busy_q;

endmodule
